// File: rtl/shift_engine_if.sv
// Bus bundle for shift_engine: strobes, parallel/serial data and status.
interface shift_engine_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             peripheralClkEdge;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] parallelDataIn;
  logic             serialDataIn;
  logic             serialDataOut;
  logic [WIDTH-1:0] parallelDataOut;
  logic             busy;
  logic             done;
  logic [CW-1:0]    bitCount;

  // Controller side: issues requests and data, observes status.
  modport master (
    output peripheralClkEdge, start, abort, parallelDataIn, serialDataIn,
    input  serialDataOut, parallelDataOut, busy, done, bitCount
  );

  // Engine side.
  modport slave (
    input  peripheralClkEdge, start, abort, parallelDataIn, serialDataIn,
    output serialDataOut, parallelDataOut, busy, done, bitCount
  );
endinterface

// File: rtl/shift_engine.sv
// Full-duplex serial shift engine: loads a word, shifts it out one bit per
// peripheral edge while shifting the receive line in, then pulses done.
module shift_engine #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic           clk,
  input logic           reset,
  shift_engine_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pdo_q, pdo_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shifted;
  logic             last_edge;

  // Register image after one shift, in the configured bit order.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {shreg_q[WIDTH-2:0], bus.serialDataIn};
    end else begin
      shifted = {bus.serialDataIn, shreg_q[WIDTH-1:1]};
    end
  end

  assign last_edge = (count_q == CW'(WIDTH - 1));

  // Next-state logic; abort outranks both start and the completing edge.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pdo_d   = pdo_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        // A simultaneous edge is ignored: the load takes the cycle.
        if (bus.start && !bus.abort) begin
          shreg_d = bus.parallelDataIn;
          count_d = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (bus.abort) begin
          count_d = '0;
          state_d = StIdle;
        end else if (bus.peripheralClkEdge) begin
          shreg_d = shifted;
          count_d = count_q + CW'(1);
          if (last_edge) begin
            pdo_d   = shifted;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.abort) begin
          count_d = '0;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      pdo_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      pdo_q   <= pdo_d;
      count_q <= count_d;
    end
  end

  assign bus.serialDataOut   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign bus.parallelDataOut = pdo_q;
  assign bus.bitCount        = count_q;
  assign bus.busy            = (state_q == StShift);
  assign bus.done            = (state_q == StDone);
endmodule
